// File: rtl/neuron_mac_serial_if.sv
// Handshake and data bundle for neuron_mac_serial: start/bias/act_sel control,
// the valid/ready x/w pair stream, and the registered result/ready/busy outputs.
interface neuron_mac_serial_if #(
    parameter int unsigned DATA_W = 16
);
    logic                     start;
    logic signed [DATA_W-1:0] bias;
    logic                     act_sel;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] w_in;
    logic signed [DATA_W-1:0] out;
    logic                     ready;
    logic                     busy;

    modport master (
        output start, bias, act_sel, in_valid, x_in, w_in,
        input  in_ready, out, ready, busy
    );

    modport slave (
        input  start, bias, act_sel, in_valid, x_in, w_in,
        output in_ready, out, ready, busy
    );
endinterface

// File: rtl/neuron_mac_serial.sv
// Serial signed fixed-point neuron: accumulate N_INPUTS x*w products, add bias, apply
// linear/ReLU activation and register the result. Define SATURATE_EN to clamp instead of wrap.
module neuron_mac_serial #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FRAC_W   = 8,
    parameter int unsigned N_INPUTS = 8
) (
    input  logic                clk,
    input  logic                rst,
    neuron_mac_serial_if.slave  bus
);
    localparam int unsigned ACC_W  = 2*DATA_W + $clog2(N_INPUTS) + 1;
    localparam int unsigned PROD_W = 2*DATA_W;
    localparam int unsigned CNT_W  = $clog2(N_INPUTS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ACT   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] bias_q, bias_d;
    logic                     act_q, act_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     ready_q, busy_q, in_ready_q;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  sum_c, res_c, relu_c;
    logic signed [DATA_W-1:0] narrow_c;

    // Full-width signed product; size casts sign-extend the operands.
    assign prod_c = PROD_W'(bus.x_in) * PROD_W'(bus.w_in);
    assign sum_c  = acc_q + (ACC_W'(bias_q) <<< FRAC_W);
    assign res_c  = sum_c >>> FRAC_W;

`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`else
    logic unused_relu_hi;
    assign unused_relu_hi = ^relu_c[ACC_W-1:DATA_W];
`endif

    // Activation first, then narrowing to DATA_W.
    always_comb begin
        relu_c = res_c;
        if (act_q && res_c[ACC_W-1]) begin
            relu_c = '0;
        end
`ifdef SATURATE_EN
        if (relu_c > SAT_MAX) begin
            narrow_c = SAT_MAX[DATA_W-1:0];
        end else if (relu_c < SAT_MIN) begin
            narrow_c = SAT_MIN[DATA_W-1:0];
        end else begin
            narrow_c = relu_c[DATA_W-1:0];
        end
`else
        narrow_c = relu_c[DATA_W-1:0];
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        act_d   = act_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bias_d  = bus.bias;
                    act_d   = bus.act_sel;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d = acc_q + ACC_W'(prod_c);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                        state_d = S_ACT;
                    end
                end
            end
            S_ACT: begin
                out_d   = narrow_c;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            bias_q     <= '0;
            act_q      <= 1'b0;
            out_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bias_q     <= bias_d;
            act_q      <= act_d;
            out_q      <= out_d;
            ready_q    <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            in_ready_q <= (state_d == S_ACCUM);
        end
    end

    assign bus.out      = out_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.in_ready = in_ready_q;
endmodule
